tick_prescaler: RTL and testbench
=================================

TICK_PRESCALER -- requirements
Module: tick_prescaler

Interface
REQ-001 SHALL have parameter DIV_W, default 8, width of the divisor and phase counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  start request, sampled each cycle.
REQ-005 SHALL have port stop  input  1  stop request, sampled each cycle.
REQ-006 SHALL have port hold  input  1  freeze prescaler while RUN.
REQ-007 SHALL have port div_in  input  DIV_W  new divisor value.
REQ-008 SHALL have port div_valid  input  1  div_in offered.
REQ-009 SHALL have port div_ready  output  1  divisor load accepted this cycle when high with div_valid.
REQ-010 SHALL have port tick  output  DIV_W-independent 1  registered one-cycle enable pulse for the downstream counter.
REQ-011 SHALL have port running  output  1  high in RUN state.
REQ-012 SHALL have port phase  output  DIV_W  current prescale count.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and RUN; running = (state == RUN).
REQ-014 SHALL hold divisor register div_q; tick period in RUN SHALL be div_q+1 cycles.
REQ-015 SHALL drive div_ready high only in IDLE; div_valid && div_ready SHALL load div_in into div_q at that edge.
REQ-016 SHALL, in IDLE with start=1 and stop=0, enter RUN next cycle with phase=0; a divisor load in the same cycle SHALL apply from the first RUN cycle.
REQ-017 SHALL, in RUN with stop=0 and hold=0: if phase==div_q then phase<=0 and tick<=1, else phase<=phase+1 and tick<=0.
REQ-018 SHALL, in RUN with hold=1 and stop=0, keep phase unchanged and drive tick<=0.
REQ-019 SHALL, in RUN with stop=1, enter IDLE next cycle with phase<=0 and tick<=0, overriding hold and any pending tick.
REQ-020 SHALL give stop priority over start when both are high in IDLE (stay IDLE).
REQ-021 SHALL ignore start while in RUN and stop while in IDLE.
REQ-022 SHALL, with div_q=0, assert tick every RUN cycle after the first (continuous high while not held).
REQ-023 SHALL, with div_q all-ones, produce period 2^DIV_W with phase wrapping to 0, never exceeding div_q.
REQ-024 SHALL keep tick=0 and phase=0 throughout IDLE.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, set state=IDLE, div_q=0, phase=0, tick=0, overriding all other inputs including mid-RUN.
REQ-026 SHALL present running=0 and div_ready=1 in the cycle after reset.

Configuration
REQ-027 SHALL recognise macro TICK_PRESCALER_ONESHOT_EN.
REQ-028 SHALL, with TICK_PRESCALER_ONESHOT_EN defined, add input oneshot (1 bit), captured with start; when captured high, FSM SHALL return to IDLE (phase 0) on the edge that produces the first tick.
REQ-029 SHALL, without TICK_PRESCALER_ONESHOT_EN, omit the oneshot port and always run continuously until stop or reset.

Verification
REQ-030 SHALL verify: reset, load div_in=3 in IDLE, pulse start -> running=1 next cycle, first tick 4 cycles after start edge, then every 4 cycles.
REQ-031 SHALL verify: div_q=3 running, hold high 5 cycles at phase=2 -> phase stays 2, no tick; after release tick after 2 further cycles.
REQ-032 SHALL verify: start and stop same cycle in IDLE -> running stays 0; stop in cycle phase==div_q -> no tick, IDLE, phase=0.
REQ-033 SHALL verify: div_valid=1 with div_in=7 while RUN -> div_ready=0, div_q unchanged; div_q=255 -> tick period 256.
REQ-034 SHALL verify: rst asserted mid-RUN at phase=5 -> next cycle running=0, phase=0, tick=0, div_q=0.
REQ-035 SHALL verify (ONESHOT_EN build): start with oneshot=1, div_in=2 -> exactly one tick 3 cycles later, running=0 from that same edge.

Source files
------------

// File: rtl/tick_prescaler.sv
// Programmable tick prescaler: emits a one-cycle tick every div_q+1 cycles while running.
// Optional single-tick mode is enabled by defining TICK_PRESCALER_ONESHOT_EN.
module tick_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
`ifdef TICK_PRESCALER_ONESHOT_EN
    input  logic             oneshot,
`endif
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             tick,
    output logic             running,
    output logic [DIV_W-1:0] phase
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_q;
`ifdef TICK_PRESCALER_ONESHOT_EN
    logic             oneshot_q;
`endif

    assign running   = (state == RUN);
    assign div_ready = (state == IDLE);

    // NOTE: reset is synchronous, so rst is tested inside the clocked block and kept out of the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            div_q <= '0;
            phase <= '0;
            tick  <= 1'b0;
`ifdef TICK_PRESCALER_ONESHOT_EN
            oneshot_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tick  <= 1'b0;
                    phase <= '0;
                    // A load in the start cycle is visible from the first RUN cycle.
                    if (div_valid) begin
                        div_q <= div_in;
                    end
                    if (start && !stop) begin
                        state <= RUN;
`ifdef TICK_PRESCALER_ONESHOT_EN
                        oneshot_q <= oneshot;
`endif
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        phase <= '0;
                        tick  <= 1'b0;
                    end else if (hold) begin
                        tick <= 1'b0;
                    end else if (phase == div_q) begin
                        phase <= '0;
                        tick  <= 1'b1;
`ifdef TICK_PRESCALER_ONESHOT_EN
                        if (oneshot_q) begin
                            state <= IDLE;
                        end
`endif
                    end else begin
                        phase <= phase + DIV_W'(1);
                        tick  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    phase <= '0;
                    tick  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_prescaler.sv
// Directed self-checking bench for tick_prescaler; oneshot steps build only with TICK_PRESCALER_ONESHOT_EN.
module tb_tick_prescaler;

    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic             hold;
    logic [DIV_W-1:0] div_in;
    logic             div_valid;
    logic             div_ready;
    logic             tick;
    logic             running;
    logic [DIV_W-1:0] phase;
`ifdef TICK_PRESCALER_ONESHOT_EN
    logic             oneshot;
`endif

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    tick_prescaler #(.DIV_W(DIV_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .hold      (hold),
`ifdef TICK_PRESCALER_ONESHOT_EN
        .oneshot   (oneshot),
`endif
        .div_in    (div_in),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .tick      (tick),
        .running   (running),
        .phase     (phase)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0;
        div_in = '0; div_valid = 1'b0;
`ifdef TICK_PRESCALER_ONESHOT_EN
        oneshot = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
        chk("rst_running", running, 0);
        chk("rst_div_ready", div_ready, 1);
        chk("rst_tick", tick, 0);
        chk("rst_phase", phase, 0);
        chk("rst_div_q", dut.div_q, 0);

        // Load 3 together with start: period 4, first tick 4 edges after start.
        div_in = 8'd3; div_valid = 1'b1; start = 1'b1;
        step();
        div_valid = 1'b0; start = 1'b0;
        chk("start_running", running, 1);
        chk("start_phase", phase, 0);
        chk("start_tick", tick, 0);
        chk("start_div_q", dut.div_q, 3);
        chk("run_div_ready", div_ready, 0);
        for (int c = 1; c <= 12; c++) begin
            step();
            chk("p4_tick", tick, (c % 4 == 0) ? 1 : 0);
            chk("p4_phase", phase, c % 4);
        end

        // Hold at phase 2 for five cycles.
        step(); step();
        chk("pre_hold_phase", phase, 2);
        hold = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("hold_phase", phase, 2);
            chk("hold_tick", tick, 0);
        end
        hold = 1'b0;
        step();
        chk("rel1_phase", phase, 3);
        chk("rel1_tick", tick, 0);
        step();
        chk("rel2_tick", tick, 1);
        chk("rel2_phase", phase, 0);

        // Stop exactly when phase == div_q: no tick, back to IDLE.
        step(); step(); step();
        chk("pre_stop_phase", phase, 3);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_running", running, 0);
        chk("stop_tick", tick, 0);
        chk("stop_phase", phase, 0);

        // Start and stop together in IDLE: stop wins.
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("ss_running", running, 0);
        step();
        chk("idle_tick", tick, 0);
        chk("idle_phase", phase, 0);

        // Divisor offered while running is refused.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_running", running, 1);
        div_in = 8'd7; div_valid = 1'b1;
        #1;
        chk("run_ready_low", div_ready, 0);
        step();
        div_valid = 1'b0;
        chk("run_load_ignored", dut.div_q, 3);
        chk("run_load_phase", phase, 1);
        step(); step();
        chk("run_load_pre_tick", tick, 0);
        step();
        chk("run_load_tick", tick, 1);

        // div_q = 255: period 256 with phase reaching 255 then wrapping.
        stop = 1'b1;
        step();
        stop = 1'b0;
        div_in = 8'd255; div_valid = 1'b1; start = 1'b1;
        step();
        div_valid = 1'b0; start = 1'b0;
        chk("d255_div_q", dut.div_q, 255);
        for (int p = 0; p < 2; p++) begin
            int early_ticks = 0;
            for (int c = 1; c <= 255; c++) begin
                step();
                if (tick) early_ticks++;
            end
            chk("d255_no_early_tick", early_ticks, 0);
            chk("d255_max_phase", phase, 255);
            step();
            chk("d255_tick", tick, 1);
            chk("d255_wrap", phase, 0);
        end

        // Reset mid-RUN at phase 5.
        stop = 1'b1;
        step();
        stop = 1'b0;
        div_in = 8'd9; div_valid = 1'b1; start = 1'b1;
        step();
        div_valid = 1'b0; start = 1'b0;
        for (int c = 0; c < 5; c++) step();
        chk("pre_rst_phase", phase, 5);
        rst = 1'b1; start = 1'b1; div_valid = 1'b1;
        step();
        rst = 1'b0; start = 1'b0; div_valid = 1'b0;
        chk("mid_rst_running", running, 0);
        chk("mid_rst_phase", phase, 0);
        chk("mid_rst_tick", tick, 0);
        chk("mid_rst_div_q", dut.div_q, 0);
        chk("mid_rst_ready", div_ready, 1);

        // div_q = 0: tick every RUN cycle after the first.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("d0_first_tick", tick, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("d0_tick", tick, 1);
            chk("d0_phase", phase, 0);
        end
        hold = 1'b1;
        step();
        hold = 1'b0;
        chk("d0_hold_tick", tick, 0);
        step();
        chk("d0_release_tick", tick, 1);

`ifdef TICK_PRESCALER_ONESHOT_EN
        stop = 1'b1;
        step();
        stop = 1'b0;
        oneshot = 1'b1; div_in = 8'd2; div_valid = 1'b1; start = 1'b1;
        step();
        oneshot = 1'b0; div_valid = 1'b0; start = 1'b0;
        chk("os_running", running, 1);
        step();
        chk("os_ph1", phase, 1);
        chk("os_ph1_tick", tick, 0);
        step();
        chk("os_ph2_tick", tick, 0);
        step();
        chk("os_tick", tick, 1);
        chk("os_running_off", running, 0);
        chk("os_phase", phase, 0);
        step();
        chk("os_after_tick", tick, 0);
        chk("os_after_running", running, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
